// File: rtl/fixed_att_pkg.sv
// Shared types and helpers for the attention input fork.
package fixed_att_pkg;

  typedef enum logic [1:0] {
    BR_Q = 2'd0,
    BR_K = 2'd1,
    BR_V = 2'd2
  } br_e;

  function automatic int tiles_per_matrix(int num_par, int depth);
    return num_par * depth;
  endfunction

endpackage

// File: rtl/fixed_att_fork_src.sv
// One source unit: shared tile register broadcast to NUM_BR branches, each
// with its own pending bit so branches drain independently.
module fixed_att_fork_src #(
  parameter int NUM_BR     = 6,
  parameter int TILE_ELEMS = 9,
  parameter int DATA_WIDTH = 8,
  parameter int TILES      = 6
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] src_data,
  input  logic                                 src_valid,
  output logic                                 src_ready,
  input  logic [NUM_BR-1:0]                    br_ready,
  output logic [NUM_BR-1:0]                    br_valid,
  output logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] tile,
  output logic                                 last
);

  localparam int CW = (TILES > 1) ? $clog2(TILES) : 1;

  logic [NUM_BR-1:0] pend;
  logic [CW-1:0]     cnt;
  logic              cnt_wrap;
  logic              accept;

  // Free when nothing is left pending after this cycle's drains; never
  // looks at src_valid.
  assign src_ready = &(~pend | br_ready);
  assign accept    = src_valid & src_ready;
  assign cnt_wrap  = (cnt == CW'(TILES - 1));
  assign br_valid  = pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= '0;
      cnt  <= '0;
      tile <= '0;
      last <= 1'b0;
    end else if (accept) begin
      // A reload overrides any drain of the final pending bits.
      pend <= '1;
      tile <= src_data;
      last <= cnt_wrap;
      cnt  <= cnt_wrap ? '0 : cnt + 1'b1;
    end else begin
      pend <= pend & ~br_ready;
    end
  end

endmodule

// File: rtl/fixed_att_input_fork.sv
// Broadcasts input tiles to the Q/K/V projection branches of every head,
// from one shared source (self-attention) or two (cross-attention).
module fixed_att_input_fork
  import fixed_att_pkg::*;
#(
  parameter int DATA_WIDTH         = 8,
  parameter int IN_PARALLELISM     = 3,
  parameter int IN_SIZE            = 3,
  parameter int IN_NUM_PARALLELISM = 2,
  parameter int IN_DEPTH           = 3,
  parameter int NUM_HEADS          = 2,
  parameter int CROSS_ATT          = 0,
  localparam int TILE_ELEMS        = IN_PARALLELISM * IN_SIZE,
  localparam int TILES             = tiles_per_matrix(IN_NUM_PARALLELISM, IN_DEPTH)
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0]                data_in,
  input  logic                                                 data_in_valid,
  output logic                                                 data_in_ready,
  input  logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0]                kv_in,
  input  logic                                                 kv_in_valid,
  output logic                                                 kv_in_ready,
  output logic [NUM_HEADS-1:0][TILE_ELEMS-1:0][DATA_WIDTH-1:0] q_out,
  output logic [NUM_HEADS-1:0][TILE_ELEMS-1:0][DATA_WIDTH-1:0] k_out,
  output logic [NUM_HEADS-1:0][TILE_ELEMS-1:0][DATA_WIDTH-1:0] v_out,
  output logic [NUM_HEADS-1:0]                                 q_out_valid,
  output logic [NUM_HEADS-1:0]                                 k_out_valid,
  output logic [NUM_HEADS-1:0]                                 v_out_valid,
  input  logic [NUM_HEADS-1:0]                                 q_out_ready,
  input  logic [NUM_HEADS-1:0]                                 k_out_ready,
  input  logic [NUM_HEADS-1:0]                                 v_out_ready,
  output logic [NUM_HEADS-1:0]                                 q_out_last,
  output logic [NUM_HEADS-1:0]                                 k_out_last,
  output logic [NUM_HEADS-1:0]                                 v_out_last
);

  localparam int NH = NUM_HEADS;
  localparam int QO = int'(BR_Q) * NH;
  localparam int KO = int'(BR_K) * NH;
  localparam int VO = int'(BR_V) * NH;

  if (CROSS_ATT == 0) begin : g_self
    logic [3*NH-1:0]                         rdy;
    logic [3*NH-1:0]                         vld;
    logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0]   tile;
    logic                                    last;
    logic                                    unused_kv;

    // Branch index = branch kind * NUM_HEADS + head.
    assign rdy = {v_out_ready, k_out_ready, q_out_ready};

    fixed_att_fork_src #(
      .NUM_BR(3*NH), .TILE_ELEMS(TILE_ELEMS), .DATA_WIDTH(DATA_WIDTH), .TILES(TILES)
    ) u_src (
      .clk(clk), .rst(rst),
      .src_data(data_in), .src_valid(data_in_valid), .src_ready(data_in_ready),
      .br_ready(rdy), .br_valid(vld), .tile(tile), .last(last)
    );

    assign q_out_valid = vld[QO +: NH];
    assign k_out_valid = vld[KO +: NH];
    assign v_out_valid = vld[VO +: NH];
    assign q_out       = {NH{tile}};
    assign k_out       = {NH{tile}};
    assign v_out       = {NH{tile}};
    assign q_out_last  = {NH{last}};
    assign k_out_last  = {NH{last}};
    assign v_out_last  = {NH{last}};
    assign kv_in_ready = 1'b0;
    assign unused_kv   = ^{kv_in, kv_in_valid};
  end else begin : g_cross
    logic [NH-1:0]                           q_vld;
    logic [2*NH-1:0]                         kv_rdy;
    logic [2*NH-1:0]                         kv_vld;
    logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0]   q_tile;
    logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0]   kv_tile;
    logic                                    q_last;
    logic                                    kv_last;

    fixed_att_fork_src #(
      .NUM_BR(NH), .TILE_ELEMS(TILE_ELEMS), .DATA_WIDTH(DATA_WIDTH), .TILES(TILES)
    ) u_q_src (
      .clk(clk), .rst(rst),
      .src_data(data_in), .src_valid(data_in_valid), .src_ready(data_in_ready),
      .br_ready(q_out_ready), .br_valid(q_vld), .tile(q_tile), .last(q_last)
    );

    // K heads occupy the low half of the K/V source, V heads the high half.
    assign kv_rdy = {v_out_ready, k_out_ready};

    fixed_att_fork_src #(
      .NUM_BR(2*NH), .TILE_ELEMS(TILE_ELEMS), .DATA_WIDTH(DATA_WIDTH), .TILES(TILES)
    ) u_kv_src (
      .clk(clk), .rst(rst),
      .src_data(kv_in), .src_valid(kv_in_valid), .src_ready(kv_in_ready),
      .br_ready(kv_rdy), .br_valid(kv_vld), .tile(kv_tile), .last(kv_last)
    );

    assign q_out_valid = q_vld;
    assign k_out_valid = kv_vld[0 +: NH];
    assign v_out_valid = kv_vld[NH +: NH];
    assign q_out       = {NH{q_tile}};
    assign k_out       = {NH{kv_tile}};
    assign v_out       = {NH{kv_tile}};
    assign q_out_last  = {NH{q_last}};
    assign k_out_last  = {NH{kv_last}};
    assign v_out_last  = {NH{kv_last}};
  end

endmodule

// File: tb/tb_fixed_att_input_fork.sv
// Checks a self-attention and a cross-attention fork against per-branch
// expected-tile queues built from the handshake rules.
module tb_fixed_att_input_fork;

  localparam int DW = 8;
  localparam int TE = 9;
  localparam int NH = 2;
  localparam int TILES = 6;

  typedef logic [TE-1:0][DW-1:0] tile_t;
  typedef struct packed { logic [TE*DW-1:0] d; logic l; } ent_t;

  logic clk, rst;
  tile_t din0, kin0, din1, kin1;
  logic dv0, kvv0, dv1, kvv1, dr0, kr0, dr1, kr1;
  logic [5:0] rdy0, rdy1;
  logic [NH-1:0][TE-1:0][DW-1:0] qd0, kd0, vd0, qd1, kd1, vd1;
  logic [NH-1:0] qv0, kv0, vv0, ql0, kl0, vl0, qv1, kv1, vv1, ql1, kl1, vl1;

  int checks = 0;
  int failures = 0;
  ent_t mq[12][$];
  int cnt[2][2];
  int tot[2][2];
  logic acc[2][2];

  fixed_att_input_fork #(.CROSS_ATT(0)) u_self (
    .clk(clk), .rst(rst),
    .data_in(din0), .data_in_valid(dv0), .data_in_ready(dr0),
    .kv_in(kin0), .kv_in_valid(kvv0), .kv_in_ready(kr0),
    .q_out(qd0), .k_out(kd0), .v_out(vd0),
    .q_out_valid(qv0), .k_out_valid(kv0), .v_out_valid(vv0),
    .q_out_ready(rdy0[1:0]), .k_out_ready(rdy0[3:2]), .v_out_ready(rdy0[5:4]),
    .q_out_last(ql0), .k_out_last(kl0), .v_out_last(vl0)
  );

  fixed_att_input_fork #(.CROSS_ATT(1)) u_cross (
    .clk(clk), .rst(rst),
    .data_in(din1), .data_in_valid(dv1), .data_in_ready(dr1),
    .kv_in(kin1), .kv_in_valid(kvv1), .kv_in_ready(kr1),
    .q_out(qd1), .k_out(kd1), .v_out(vd1),
    .q_out_valid(qv1), .k_out_valid(kv1), .v_out_valid(vv1),
    .q_out_ready(rdy1[1:0]), .k_out_ready(rdy1[3:2]), .v_out_ready(rdy1[5:4]),
    .q_out_last(ql1), .k_out_last(kl1), .v_out_last(vl1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int d, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s dut%0d obs=%0h exp=%0h", tag, d, o, e);
    end
  endtask

  function automatic tile_t rnd_tile();
    tile_t t;
    for (int e = 0; e < TE; e++) t[e] = DW'($urandom);
    return t;
  endfunction

  // Which source of dut d feeds branch b (b = kind*NH + head).
  function automatic int owner(input int d, input int b);
    return (d == 1 && b >= NH) ? 1 : 0;
  endfunction

  // Compare one cycle at the falling edge, then advance the model to the
  // next rising edge.
  task automatic cyc();
    logic [5:0] ov, ol, rd;
    logic [5:0][TE*DW-1:0] od;
    logic [1:0] srv, obs_r, pr;
    tile_t sd[2];
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        ov = {vv0, kv0, qv0}; ol = {vl0, kl0, ql0}; od = {vd0, kd0, qd0};
        rd = rdy0; srv = {kvv0, dv0}; obs_r = {kr0, dr0}; sd[0] = din0; sd[1] = kin0;
      end else begin
        ov = {vv1, kv1, qv1}; ol = {vl1, kl1, ql1}; od = {vd1, kd1, qd1};
        rd = rdy1; srv = {kvv1, dv1}; obs_r = {kr1, dr1}; sd[0] = din1; sd[1] = kin1;
      end
      if (!rst) begin
        chk("rst_valid", d, ov, 0);
        chk("rst_last", d, ol, 0);
        for (int b = 0; b < 6; b++) chk("rst_data", d, od[b], 0);
        chk("rst_data_in_ready", d, obs_r[0], 1);
        chk("rst_kv_in_ready", d, obs_r[1], (d == 1));
        for (int b = 0; b < 6; b++) mq[d*6+b].delete();
        cnt[d][0] = 0; cnt[d][1] = 0;
        acc[d][0] = 1'b0; acc[d][1] = 1'b0;
        continue;
      end
      pr = 2'b11;
      for (int b = 0; b < 6; b++)
        if (mq[d*6+b].size() != 0 && !rd[b]) pr[owner(d, b)] = 1'b0;
      if (d == 0) pr[1] = 1'b0;
      chk("data_in_ready", d, obs_r[0], pr[0]);
      chk("kv_in_ready", d, obs_r[1], pr[1]);
      for (int b = 0; b < 6; b++) begin
        chk("out_valid", d, ov[b], mq[d*6+b].size() != 0);
        if (mq[d*6+b].size() != 0) begin
          chk("out_data", d, od[b], mq[d*6+b][0].d);
          chk("out_last", d, ol[b], mq[d*6+b][0].l);
          if (rd[b]) void'(mq[d*6+b].pop_front());
        end
      end
      for (int s = 0; s < 2; s++) begin
        acc[d][s] = srv[s] && pr[s];
        if (acc[d][s]) begin
          for (int b = 0; b < 6; b++)
            if (owner(d, b) == s) mq[d*6+b].push_back('{d: sd[s], l: (cnt[d][s] % TILES) == TILES-1});
          cnt[d][s]++;
          tot[d][s]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    din0 = '0; kin0 = '0; din1 = '0; kin1 = '0;
    dv0 = 1'b0; kvv0 = 1'b0; dv1 = 1'b0; kvv1 = 1'b0;
    rdy0 = '0; rdy1 = '0;
    for (int d = 0; d < 2; d++) for (int s = 0; s < 2; s++) begin
      cnt[d][s] = 0; tot[d][s] = 0; acc[d][s] = 1'b0;
    end
    repeat (2) cyc();
    rst = 1'b1;

    // Self mode: 12 back-to-back tiles, all readies high; kv_in driven but ignored.
    rdy0 = '1; rdy1 = '1; dv0 = 1'b1; kvv0 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      din0 = rnd_tile(); kin0 = rnd_tile();
      cyc();
    end
    dv0 = 1'b0;
    repeat (2) cyc();

    // Self mode: head-1 K branch stalls for 4 cycles after tile 0.
    dv0 = 1'b1; din0 = rnd_tile();
    cyc();
    din0 = rnd_tile(); rdy0 = 6'b110111;
    repeat (4) cyc();
    rdy0 = '1;
    cyc();
    dv0 = 1'b0;
    repeat (2) cyc();

    // Cross mode: 6 query tiles while kv_in stays idle.
    dv1 = 1'b1; kvv1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      din1 = rnd_tile();
      cyc();
    end
    dv1 = 1'b0;
    repeat (2) cyc();

    // Random readies and valids, 60 tiles per source.
    for (int d = 0; d < 2; d++) for (int s = 0; s < 2; s++) tot[d][s] = 0;
    for (int c = 0; c < 4000; c++) begin
      if (tot[0][0] >= 60 && tot[1][0] >= 60 && tot[1][1] >= 60) break;
      rdy0 = 6'($urandom) | 6'($urandom);
      rdy1 = 6'($urandom) | 6'($urandom);
      if (!dv0 || acc[0][0]) begin
        dv0 = (tot[0][0] < 60) && ($urandom_range(3) != 0); din0 = rnd_tile();
      end
      if (!dv1 || acc[1][0]) begin
        dv1 = (tot[1][0] < 60) && ($urandom_range(3) != 0); din1 = rnd_tile();
      end
      if (!kvv1 || acc[1][1]) begin
        kvv1 = (tot[1][1] < 60) && ($urandom_range(3) != 0); kin1 = rnd_tile();
      end
      kin0 = rnd_tile();
      cyc();
    end
    dv0 = 1'b0; dv1 = 1'b0; kvv1 = 1'b0; rdy0 = '1; rdy1 = '1;
    repeat (3) cyc();
    chk("tiles_self", 0, tot[0][0], 60);
    chk("tiles_cross_q", 1, tot[1][0], 60);
    chk("tiles_cross_kv", 1, tot[1][1], 60);

    // Async reset with 3 branches pending and tile_cnt = 4.
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    dv0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din0 = rnd_tile();
      cyc();
    end
    dv0 = 1'b0; rdy0 = 6'b101010;
    cyc();
    chk("pending_before_rst", 0, {vv0, kv0, qv0}, 6'b010101);
    rst = 1'b0;
    #2;
    chk("async_valid", 0, {vv0, kv0, qv0}, 0);
    chk("async_last", 0, {vl0, kl0, ql0}, 0);
    chk("async_valid", 1, {vv1, kv1, qv1}, 0);
    cyc();
    rst = 1'b1; rdy0 = '1; dv0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din0 = rnd_tile();
      cyc();
    end
    dv0 = 1'b0;
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
